serial_addsub_sat: RTL and testbench

- Parametrised signed two's-complement adder/subtractor; digit-serial datapath processes DIGIT bits per clock through one shared ripple slice.
- Successor to the fixed 4-bit combinational adder. Adds width/digit parametrisation, subtract mode, valid/ready handshake, and registered overflow/carry flags; there is no tri-state output on overflow.
- Sits between operand-producing logic and result consumers in the arithmetic lab datapath.

---
 rtl/serial_addsub_sat_pkg.sv | 27 ++
 rtl/serial_addsub_sat_digit_adder.sv | 34 +++
 rtl/serial_addsub_sat.sv | 186 ++++++++++++++++++
 tb/tb_serial_addsub_sat.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_sat_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg
// Shared types and helpers for the digit-serial signed adder/subtractor.
//   state_e    : controller states (IDLE, RUN, DONE)
//   OP_ADD/SUB : encoding of the op input
//   cnt_width  : width of the digit counter for a given WIDTH/DIGIT split
// ---------------------------------------------------------------------------
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // A single-digit configuration still needs a 1-bit counter so the
  // declaration stays legal; the counter then simply stays at zero.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_sat_digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
// Purely combinational DIGIT-bit ripple-carry slice; the serial datapath
// pushes one digit of each operand through it per RUN cycle.
// Ports:
//   x, y : DIGIT-bit addend digits
//   cin  : carry into the least significant bit of the digit
//   s    : DIGIT-bit sum digit
//   co   : carry out of the most significant bit of the digit
// ---------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // The ripple is walked bit by bit with a procedural carry so the chain
  // does not form a combinational self-loop on a vector net.
  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_addsub_sat.sv
// ---------------------------------------------------------------------------
// serial_addsub_sat
// Digit-serial signed two's-complement adder/subtractor with a valid/ready
// handshake on both sides and registered sum/overflow/carry results.
// An operation is accepted in IDLE, spends WIDTH/DIGIT cycles in RUN
// pushing one digit per cycle through a shared ripple slice, and then
// waits in DONE until the consumer takes the result.
//
// Parameters:
//   WIDTH : operand/result width (>= 2, multiple of DIGIT)
//   DIGIT : bits processed per RUN cycle (1..WIDTH)
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operands and op are valid
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : signed operands
//   op        : 0 = a+b, 1 = a-b
//   out_valid : result valid (DONE)
//   out_ready : consumer accepts the result
//   sum       : signed result
//   ovf       : signed overflow of the true result
//   cout      : carry out of the MSB; for subtract 1 = no borrow
//
// Build option:
//   SERIAL_ADDSUB_SAT_EN : when defined, an overflowing result saturates to
//                          the most positive / most negative value (chosen
//                          by the sign of a); ovf and cout still report the
//                          raw event. When undefined the sum wraps.
// ---------------------------------------------------------------------------
module serial_addsub_sat
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             cout
);

  localparam int            N        = WIDTH / DIGIT;
  localparam int            CW       = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;

  logic [DIGIT-1:0] slice_x, slice_y, slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] raw_full;
  logic             ovf_now;

  assign slice_x = a_q[cnt_q*DIGIT +: DIGIT];
  assign slice_y = b_q[cnt_q*DIGIT +: DIGIT];

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x  (slice_x),
    .y  (slice_y),
    .cin(carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Partial result including the digit being produced this cycle; on the
  // last RUN cycle this is the complete raw WIDTH-bit sum.
  always_comb begin
    raw_full = acc_q;
    raw_full[cnt_q*DIGIT +: DIGIT] = slice_s;
  end

  // b has already been inverted for subtract, so one rule covers both ops:
  // like-signed addends whose sum flips sign overflowed.
  assign ovf_now = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (raw_full[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtract is a + ~b + 1: the +1 rides in as the initial carry.
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b : b;
          carry_d = op;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d   = raw_full;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d  = '0;
          ovf_d  = ovf_now;
          cout_d = slice_co;
`ifdef SERIAL_ADDSUB_SAT_EN
          if (ovf_now) begin
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            sum_d = raw_full;
          end
`else
          sum_d = raw_full;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign ovf  = ovf_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_addsub_sat.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_sat
// Self-checking bench for serial_addsub_sat. A DIGIT=2 instance receives the
// directed scenarios plus randomized traffic with back-pressure; three more
// instances (DIGIT = 1, 4, 8) run randomized traffic concurrently. All
// results are compared against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_addsub_sat;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         opIn;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] sumOut;
  logic         ovfOut;
  logic         coutOut;

  int checks = 0;
  int errors = 0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  serial_addsub_sat #(
    .WIDTH(W),
    .DIGIT(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .a        (aIn),
    .b        (bIn),
    .op       (opIn),
    .out_valid(outValid),
    .out_ready(outReady),
    .sum      (sumOut),
    .ovf      (ovfOut),
    .cout     (coutOut)
  );

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer result, range test for overflow, unsigned
  // compare for carry/borrow. Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] refModel(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic o);
    int sx, sy, ux, uy, t;
    logic ovfE, coutE;
    logic [W-1:0] sumE;
    sx = int'(signed'(x));
    sy = int'(signed'(y));
    ux = int'(x);
    uy = int'(y);
    t  = o ? (sx - sy) : (sx + sy);
    ovfE  = (t > 127) || (t < -128);
    coutE = o ? (ux >= uy) : ((ux + uy) > 255);
    sumE  = t[W-1:0];
`ifdef SERIAL_ADDSUB_SAT_EN
    if (t > 127) sumE = 8'h7F;
    if (t < -128) sumE = 8'h80;
`endif
    return {ovfE, coutE, sumE};
  endfunction

  // One full transaction on the main DUT: accept, check latency and result,
  // optionally hold the result under back-pressure while poking in_valid,
  // then release it and check the return to IDLE.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic o, input int hold, input bit poke);
    int waitCycles;
    int lat;
    logic [W+1:0] expVal;
    expVal = refModel(x, y, o);
    waitCycles = 0;
    while (!inReady && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkOutput("in_ready_before_accept", inReady, 1);
    aIn = x;
    bIn = y;
    opIn = o;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    aIn = W'($urandom);
    bIn = W'($urandom);
    opIn = 1'($urandom);
    lat = 0;
    while (!outValid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("latency", lat, 4);
    checkOutput("result", {ovfOut, coutOut, sumOut}, expVal);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        inValid = 1'b1;
        aIn = W'($urandom);
        bIn = W'($urandom);
      end
      tick();
      checkOutput("hold_out_valid", outValid, 1);
      checkOutput("hold_in_ready", inReady, 0);
      checkOutput("hold_result", {ovfOut, coutOut, sumOut}, expVal);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("release_out_valid", outValid, 0);
    checkOutput("release_in_ready", inReady, 1);
  endtask

  // Sweep instances for the other digit sizes, each with its own traffic.
  for (genvar gi = 0; gi < 3; gi++) begin : genSweep
    localparam int DG = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
    logic         sRst, sInValid, sInReady, sOp, sOutValid, sOutReady;
    logic         sOvf, sCout;
    logic [W-1:0] sA, sB, sSum;
    bit           done = 1'b0;

    serial_addsub_sat #(
      .WIDTH(W),
      .DIGIT(DG)
    ) sweepDut (
      .clk      (clk),
      .rst      (sRst),
      .in_valid (sInValid),
      .in_ready (sInReady),
      .a        (sA),
      .b        (sB),
      .op       (sOp),
      .out_valid(sOutValid),
      .out_ready(sOutReady),
      .sum      (sSum),
      .ovf      (sOvf),
      .cout     (sCout)
    );

    initial begin
      logic [W-1:0] x, y;
      logic o;
      int w, lat;
      sRst = 1'b1;
      sInValid = 1'b0;
      sOutReady = 1'b0;
      sA = '0;
      sB = '0;
      sOp = 1'b0;
      tick();
      tick();
      sRst = 1'b0;
      checkOutput("sweep_reset_ready", sInReady, 1);
      checkOutput("sweep_reset_valid", sOutValid, 0);
      for (int k = 0; k < 1000; k++) begin
        w = 0;
        while (!sInReady && w < 20) begin
          tick();
          w++;
        end
        x = W'($urandom);
        y = W'($urandom);
        o = 1'($urandom_range(0, 1));
        sA = x;
        sB = y;
        sOp = o;
        sInValid = 1'b1;
        tick();
        sInValid = 1'b0;
        lat = 0;
        while (!sOutValid && lat < 40) begin
          tick();
          lat++;
        end
        checkOutput("sweep_latency", lat, W / DG);
        checkOutput("sweep_result", {sOvf, sCout, sSum}, refModel(x, y, o));
        sOutReady = 1'b1;
        tick();
        sOutReady = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    aIn = '0;
    bIn = '0;
    opIn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_in_ready", inReady, 1);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_sum", sumOut, 0);
    checkOutput("reset_ovf", ovfOut, 0);
    checkOutput("reset_cout", coutOut, 0);

    applyStimulus(8'd100, 8'd27, 1'b0, 0, 1'b0);
    checkOutput("sum_100p27", sumOut, 8'h7F);
    checkOutput("ovf_100p27", ovfOut, 0);
    checkOutput("cout_100p27", coutOut, 0);

    applyStimulus(8'd100, 8'd28, 1'b0, 0, 1'b0);
    checkOutput("ovf_100p28", ovfOut, 1);
    checkOutput("cout_100p28", coutOut, 0);
`ifdef SERIAL_ADDSUB_SAT_EN
    checkOutput("sum_100p28", sumOut, 8'h7F);
`else
    checkOutput("sum_100p28", sumOut, 8'h80);
`endif

    applyStimulus(8'h80, 8'd1, 1'b1, 0, 1'b0);
    checkOutput("ovf_m128m1", ovfOut, 1);
    checkOutput("cout_m128m1", coutOut, 1);
`ifdef SERIAL_ADDSUB_SAT_EN
    checkOutput("sum_m128m1", sumOut, 8'h80);
`else
    checkOutput("sum_m128m1", sumOut, 8'h7F);
`endif

    applyStimulus(8'd5, 8'd7, 1'b1, 0, 1'b0);
    checkOutput("sum_5m7", sumOut, 8'hFE);
    checkOutput("ovf_5m7", ovfOut, 0);
    checkOutput("cout_5m7", coutOut, 0);

    // Subtracting the most negative value, both signs of a.
    applyStimulus(8'd10, 8'h80, 1'b1, 0, 1'b0);
    applyStimulus(8'hF6, 8'h80, 1'b1, 0, 1'b0);

    // Back-pressure with a second in_valid presented during DONE.
    applyStimulus(8'd33, 8'hF0, 1'b0, 3, 1'b1);

    // Reset in the middle of RUN (counter at 2).
    aIn = 8'd50;
    bIn = 8'd20;
    opIn = 1'b0;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrun_rst_out_valid", outValid, 0);
    checkOutput("midrun_rst_in_ready", inReady, 1);
    checkOutput("midrun_rst_sum", sumOut, 0);
    checkOutput("midrun_rst_ovf", ovfOut, 0);
    applyStimulus(8'd3, 8'd4, 1'b0, 0, 1'b0);
    checkOutput("sum_3p4", sumOut, 8'h07);

    for (int k = 0; k < 300; k++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while (!(genSweep[0].done && genSweep[1].done && genSweep[2].done) &&
           guard < 40000) begin
      tick();
      guard++;
    end
    checkOutput("sweep_completed",
                {29'd0, genSweep[2].done, genSweep[1].done, genSweep[0].done},
                32'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
